// File: rtl/program_loader_pkg.sv
// Shared types and sizing helpers for the program loader and its hold counter.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_HOLD,
        ST_START,
        ST_RUN
    } state_e;

    // word_count needs one extra bit so that a full-memory load (2^MEM words) is representable.
    localparam int unsigned WORD_COUNT_EXTRA_BITS = 1;

    function automatic int unsigned word_count_width(input int unsigned mem_address_bits);
        return mem_address_bits + WORD_COUNT_EXTRA_BITS;
    endfunction

    function automatic int unsigned hold_counter_width(input int unsigned hold_cycles);
        return (hold_cycles < 2) ? 1 : $clog2(hold_cycles + 1);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Word stream into the loader and the word write port out to the BRAM.
interface program_loader_if #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned MEM_ADDRESS_BITS = 14
);
    logic                          in_valid;
    logic [DATA_WIDTH-1:0]         in_data;
    logic                          in_ready;
    logic                          mem_write;
    logic [MEM_ADDRESS_BITS-1:0]   mem_address;
    logic [DATA_WIDTH-1:0]         mem_write_data;
    logic [DATA_WIDTH/8-1:0]       mem_byte_enable;

    // Feeder side: produces the stream, observes the write port.
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_write, mem_address, mem_write_data, mem_byte_enable
    );

    // Loader side: consumes the stream, drives the write port.
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_write, mem_address, mem_write_data, mem_byte_enable
    );
endinterface

// File: rtl/program_loader_hold_counter.sv
// Loadable down-counter with a zero flag; saturates at zero. Used to stretch a reset.
module hold_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic             zero
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (decrement && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/program_loader.sv
// Streams a program image into the core's BRAM (optionally zero-filling first),
// holds the core in reset while loading, then releases it with a one-cycle start.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH       = 32,
    parameter int unsigned              ADDRESS_BITS     = 32,
    parameter int unsigned              MEM_ADDRESS_BITS = 14,
    parameter logic [ADDRESS_BITS-1:0]  START_ADDRESS    = '0,
    parameter int unsigned              HOLD_CYCLES      = 10
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          load_start,
    input  logic                                          load_clear,
    input  logic [word_count_width(MEM_ADDRESS_BITS)-1:0] word_count,
    program_loader_if.slave                               bus,
    output logic                                          core_reset,
    output logic                                          core_start,
    output logic [ADDRESS_BITS-1:0]                       program_address,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          error
);
    localparam int unsigned WC_W = word_count_width(MEM_ADDRESS_BITS);
    localparam int unsigned HC_W = hold_counter_width(HOLD_CYCLES);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    localparam logic [WC_W-1:0] MEM_WORDS = {1'b1, {MEM_ADDRESS_BITS{1'b0}}};
    localparam logic [WC_W-1:0] LAST_ADDR = MEM_WORDS - WC_W'(1);
    localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES);

    state_e                      state_q, state_d;
    logic [WC_W-1:0]             count_q, count_d;
    logic [WC_W-1:0]             word_count_q, word_count_d;
    logic                        mem_write_q, mem_write_d;
    logic [MEM_ADDRESS_BITS-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]       mem_write_data_q, mem_write_data_d;
    logic [BE_W-1:0]             mem_byte_enable_q, mem_byte_enable_d;
    logic                        core_reset_q, core_reset_d;
    logic                        core_start_q, core_start_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        error_q, error_d;

    logic in_ready;
    logic accept;
    logic hold_load;
    logic hold_decrement;
    logic hold_zero;

    // Ready is a pure decode so a handshake can land every cycle of LOAD.
    assign in_ready = (state_q == ST_LOAD) && (count_q < word_count_q);
    assign accept   = bus.in_valid && in_ready;

    hold_counter #(
        .WIDTH (HC_W)
    ) u_hold_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (hold_load),
        .load_value (HOLD_LOAD),
        .decrement  (hold_decrement),
        .zero       (hold_zero)
    );

    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        word_count_d     = word_count_q;
        mem_write_d      = 1'b0;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        error_d          = error_q;
        hold_load        = 1'b0;
        hold_decrement   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    error_d      = 1'b0;
                    word_count_d = word_count;
                    count_d      = '0;
                    if (word_count > MEM_WORDS) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (load_clear) begin
                        state_d = ST_CLEAR;
                    end else if (word_count == '0) begin
                        state_d   = ST_HOLD;
                        hold_load = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_CLEAR: begin
                mem_write_d      = 1'b1;
                mem_address_d    = count_q[MEM_ADDRESS_BITS-1:0];
                mem_write_data_d = '0;
                count_d          = count_q + WC_W'(1);
                if (count_q == LAST_ADDR) begin
                    count_d = '0;
                    if (word_count_q == '0) begin
                        state_d   = ST_HOLD;
                        hold_load = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    mem_write_d      = 1'b1;
                    mem_address_d    = count_q[MEM_ADDRESS_BITS-1:0];
                    mem_write_data_d = bus.in_data;
                    count_d          = count_q + WC_W'(1);
                    if (count_q == word_count_q - WC_W'(1)) begin
                        state_d   = ST_HOLD;
                        hold_load = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // The counter is loaded on entry, so HOLD spans the final write cycle plus HOLD_CYCLES.
                if (hold_zero) begin
                    state_d = ST_START;
                end else begin
                    hold_decrement = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up with it.
        mem_byte_enable_d = {BE_W{mem_write_d}};
        core_reset_d      = !((state_d == ST_START) || (state_d == ST_RUN));
        core_start_d      = (state_d == ST_START);
        busy_d            = (state_d == ST_CLEAR) || (state_d == ST_LOAD) || (state_d == ST_HOLD);
        done_d            = (state_d == ST_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            count_q           <= '0;
            word_count_q      <= '0;
            mem_write_q       <= 1'b0;
            mem_address_q     <= '0;
            mem_write_data_q  <= '0;
            mem_byte_enable_q <= '0;
            core_reset_q      <= 1'b1;
            core_start_q      <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            error_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            count_q           <= count_d;
            word_count_q      <= word_count_d;
            mem_write_q       <= mem_write_d;
            mem_address_q     <= mem_address_d;
            mem_write_data_q  <= mem_write_data_d;
            mem_byte_enable_q <= mem_byte_enable_d;
            core_reset_q      <= core_reset_d;
            core_start_q      <= core_start_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            error_q           <= error_d;
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.mem_write       = mem_write_q;
    assign bus.mem_address     = mem_address_q;
    assign bus.mem_write_data  = mem_write_data_q;
    assign bus.mem_byte_enable = mem_byte_enable_q;
    assign core_reset          = core_reset_q;
    assign core_start          = core_start_q;
    assign program_address     = START_ADDRESS;
    assign busy                = busy_q;
    assign done                = done_q;
    assign error               = error_q;
endmodule
